// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - note codes, nominal half-periods and the shared classifier
package note_pkg;

  typedef enum logic [2:0] {
    NOTE_REST    = 3'd0,
    NOTE_D4      = 3'd1,
    NOTE_DS4     = 3'd2,
    NOTE_E4      = 3'd3,
    NOTE_F4      = 3'd4,
    NOTE_FS4     = 3'd5,
    NOTE_G4      = 3'd6,
    NOTE_UNKNOWN = 3'd7
  } note_code_t;

  // Half-periods in 50 MHz ticks, shared with the tone sequencer
  localparam int unsigned NOM_D4  = 85131;
  localparam int unsigned NOM_DS4 = 80353;
  localparam int unsigned NOM_E4  = 75843;
  localparam int unsigned NOM_F4  = 71586;
  localparam int unsigned NOM_FS4 = 67568;
  localparam int unsigned NOM_G4  = 63776;

  localparam int unsigned DEF_TOL_TICKS     = 1024;
  localparam int unsigned DEF_TIMEOUT_TICKS = 200_000;

  function automatic int unsigned nominal_ticks(input note_code_t c, input int unsigned div);
    case (c)
      NOTE_D4:  return NOM_D4 / div;
      NOTE_DS4: return NOM_DS4 / div;
      NOTE_E4:  return NOM_E4 / div;
      NOTE_F4:  return NOM_F4 / div;
      NOTE_FS4: return NOM_FS4 / div;
      NOTE_G4:  return NOM_G4 / div;
      default:  return 0;
    endcase
  endfunction

  function automatic note_code_t classify(input logic [19:0] measured, input int unsigned tol,
                                          input int unsigned div);
    int unsigned m;
    int unsigned nom;
    int unsigned diff;
    note_code_t  cls;
    m   = {12'd0, measured};
    cls = NOTE_UNKNOWN;
    for (int i = 1; i <= 6; i++) begin
      nom  = nominal_ticks(note_code_t'(i[2:0]), div);
      diff = (m >= nom) ? m - nom : nom - m;
      if (cls == NOTE_UNKNOWN && diff <= tol) cls = note_code_t'(i[2:0]);
    end
    return cls;
  endfunction

endpackage

// File: rtl/note_decoder_meter.sv
// rtl/note_decoder_meter.sv - tone_period_meter: synchronizer, edge detect, saturating half-period counter
module tone_period_meter
  import note_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic        edge_stb,
  output logic [19:0] measured,
  output logic        timeout_stb
);

  localparam logic [19:0] TMO = 20'(TIMEOUT_TICKS);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [19:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d     = tone_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    edge_stb    = sync2_q ^ prev_q;
    measured    = cnt_q + 20'd1;
    // Fires once, on the cycle the counter would reach the limit; an edge suppresses it
    timeout_stb = !edge_stb && (cnt_q == TMO - 20'd1);
    cnt_d       = cnt_q;
    if (edge_stb) cnt_d = '0;
    else if (cnt_q != TMO) cnt_d = cnt_q + 20'd1;
  end

endmodule

// File: rtl/note_decoder.sv
// rtl/note_decoder.sv - classifies measured half-periods and locks onto a note after repeated agreement
module note_decoder
  import note_pkg::*;
#(
  parameter int unsigned TOL_TICKS     = DEF_TOL_TICKS,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int unsigned CONFIRM_COUNT = 3,
  // Divides the nominal table; 1 for the real 50 MHz tones
  parameter int unsigned NOM_DIV       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tone_in,
  output logic [2:0]  note_code,
  output logic        note_valid,
  output logic        note_change,
  output logic [19:0] period_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_TRACK} state_t;

  localparam int MW = $clog2(CONFIRM_COUNT + 1);
  localparam logic [MW-1:0] CONFIRM = MW'(CONFIRM_COUNT);

  logic        edge_stb, timeout_stb;
  logic [19:0] measured;
  note_code_t  cls;

  state_t      state_q, state_d;
  note_code_t  cand_q, cand_d;
  logic [MW-1:0] match_q, match_d;
  note_code_t  code_q, code_d;
  logic        valid_q, valid_d;
  logic        change_q, change_d;
  logic [19:0] period_q, period_d;

  tone_period_meter #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_meter (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .edge_stb    (edge_stb),
    .measured    (measured),
    .timeout_stb (timeout_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cand_q   <= NOTE_REST;
      match_q  <= '0;
      code_q   <= NOTE_REST;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    match_d  = match_q;
    code_d   = code_q;
    change_d = 1'b0;
    period_d = period_q;
    cls      = classify(measured, TOL_TICKS, NOM_DIV);
    if (timeout_stb) begin
      state_d  = ST_IDLE;
      code_d   = NOTE_REST;
      change_d = (code_q != NOTE_REST);
      cand_d   = NOTE_REST;
      match_d  = '0;
    end else if (edge_stb) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_ARM;
      end else begin
        period_d = measured;
        if (cls == cand_q) begin
          if (match_q != CONFIRM) match_d = match_q + 1'b1;
        end else begin
          cand_d  = cls;
          match_d = MW'(1);
        end
        if (match_d == CONFIRM && cand_d != code_q) begin
          code_d   = cand_d;
          change_d = 1'b1;
          state_d  = ST_TRACK;
        end
      end
    end
    valid_d = (state_d == ST_TRACK) && (code_d != NOTE_REST) && (code_d != NOTE_UNKNOWN);
  end

  assign note_code   = code_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign period_out  = period_q;

endmodule

// File: doc/note_decoder.md
NOTE_DECODER -- requirements
Module: note_decoder

Interface
REQ-001 SHALL have parameter TOL_TICKS, default 1024, giving the max |measured - nominal| half-period error accepted as a match.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 200_000 (4 ms at 50 MHz), giving the no-edge interval that is declared silence.
REQ-003 SHALL have parameter CONFIRM_COUNT, default 3, giving the consecutive identical classifications required to lock.
REQ-004 SHALL have port clk, input, 1, the single 50 MHz system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 SHALL have port tone_in, input, 1, an asynchronous square wave from the buzzer line or comparator.
REQ-007 SHALL have port note_code, output, 3, the locked note: 0 REST, 1 D4, 2 Ds4, 3 E4, 4 F4, 5 Fs4, 6 G4, 7 UNKNOWN.
REQ-008 SHALL have port note_valid, output, 1, high while locked on codes 1-6.
REQ-009 SHALL have port note_change, output, 1, a one-cycle pulse on every note_code update.
REQ-010 SHALL have port period_out, output, 20, the last measured half-period in clk ticks.

Function
REQ-011 tone_in SHALL pass through a 2-flop synchronizer; an edge is any level change of the synchronized signal versus its previous-cycle value.
REQ-012 The half-period counter SHALL clear to 0 on an edge cycle and otherwise increment, saturating at TIMEOUT_TICKS; measured = counter + 1 on the edge cycle.
REQ-013 Classification SHALL map measured to the code whose nominal ticks (D4 85131, Ds4 80353, E4 75843, F4 71586, Fs4 67568, G4 63776) lie within TOL_TICKS inclusive, else UNKNOWN.
REQ-014 The FSM SHALL have three states: IDLE, ARM and TRACK.
REQ-015 IDLE: the first edge SHALL move the FSM to ARM and produce no measurement.
REQ-016 ARM/TRACK: each subsequent edge SHALL yield one measurement; period_out SHALL update on that cycle +1.
REQ-017 A candidate register and a match counter SHALL track classifications; a class equal to the candidate increments the match counter (saturating), and a different class reloads the candidate with the match counter set to 1.
REQ-018 When the match counter reaches CONFIRM_COUNT and the candidate differs from note_code, note_code SHALL update one cycle after that edge, note_change SHALL pulse on the same cycle, and the FSM SHALL enter TRACK.
REQ-019 If the candidate equals the current note_code, there SHALL be no update and no pulse.
REQ-020 When the counter reaches TIMEOUT_TICKS with no edge, the FSM SHALL enter IDLE, note_code SHALL become 0, note_valid SHALL become 0, and note_change SHALL pulse only if note_code was non-zero; the candidate and match counter SHALL clear.
REQ-021 If an edge and a timeout occur on the same cycle, the edge SHALL win and no timeout occurs.
REQ-022 note_valid SHALL equal (state == TRACK) and (note_code in 1..6).
REQ-023 Outputs SHALL be registered, with no combinational path from tone_in.

Reset
REQ-024 While rst is asserted, note_code SHALL be 0, note_valid 0, note_change 0, period_out 0, FSM IDLE, and counter, candidate, match counter and synchronizer flops 0.
REQ-025 Reset SHALL take effect immediately, including mid-measurement; after release, acquisition SHALL restart from IDLE.

Structure
REQ-026 note_pkg SHALL hold the note_code_t enum, the nominal half-period constants shared with the tone sequencer, and the default TOL_TICKS and TIMEOUT_TICKS values.
REQ-027 Sub-module tone_period_meter SHALL contain the synchronizer, edge detect and saturating counter, and output edge_stb plus a 20-bit measured value and a timeout strobe.
REQ-028 note_decoder SHALL contain the classifier, FSM and output registers.

Verification
REQ-029 E4 lock: square wave with 75843-cycle half-periods x8 -> note_code=3, note_valid=1 within 4 clk of the 4th input edge, exactly one note_change pulse, period_out=75843.
REQ-030 Note change: E4 locked, then G4 (63776) with no gap -> note_code stays 3 through 2 G4 measurements and becomes 6 after the 3rd, one pulse.
REQ-031 Tolerance: half-periods 76867 -> code 3; 76868 -> code 7 locked, note_valid=0.
REQ-032 Silence: locked E4, then tone_in held for 200_000 cycles -> note_code=0, note_valid=0, one pulse; 199_999 cycles of silence then an edge -> no timeout.
REQ-033 Alternation: E4,F4,E4,F4 half-periods repeated -> never locks, note_code stays 0, no pulse.
REQ-034 Mid-acquire reset: rst asserted after 2 E4 measurements -> all outputs 0 asynchronously; after release, 4 E4 edges relock to 3.
